alarm_unit: RTL

Daily alarm stage that sits directly downstream of the clock's hour/minute/second counters. It samples the running time on every one-second tick and compares it against a user-set alarm time. It drives a ringing indication with snooze and time-out behaviour. It also exports the alarm time and the set-state flags so the display selector can show and blink them.

---
 rtl/alarm_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alarm_unit.sv
// Daily alarm stage: compares the running time against a user-set alarm time
// on every one-second tick and drives ringing, snooze and time-out behaviour.
module alarm_unit #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int AH_INIT        = 7,
  parameter int AM_INIT        = 0
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       tick1s,
  input  logic [4:0] h,
  input  logic [5:0] m,
  input  logic [5:0] s,
  input  logic       btn_alarm,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_off,
  output logic [4:0] ah,
  output logic [5:0] am,
  output logic       setting_h,
  output logic       setting_m,
  output logic       armed,
  output logic       ringing,
  output logic       ring_led,
  output logic [2:0] dbg_state,
  output logic [4:0] dbg_sh,
  output logic [5:0] dbg_sm
);

  // Button interface: every btn_* is a single-cycle pulse consumed on the edge
  // that samples it; nothing is held or queued. btn_up together with btn_down
  // in one cycle is treated as no button at all.

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_SET_H   = 3'd1,
    S_SET_M   = 3'd2,
    S_ARMED   = 3'd3,
    S_RINGING = 3'd4,
    S_SNOOZE  = 3'd5
  } state_t;

  localparam logic [6:0] RC_LAST  = 7'(RING_SECONDS - 1);
  localparam logic [6:0] SNOOZE_7 = 7'(SNOOZE_MINUTES);

  state_t     state, state_n;
  logic [4:0] ah_n, sh, sh_n;
  logic [5:0] am_n, sm, sm_n;
  logic [6:0] rc, rc_n;
  logic       led_n;
  logic       up_only, dn_only;
  logic       alarm_hit, snooze_hit;
  logic [6:0] sm_tmp;

  assign up_only    = btn_up & ~btn_down;
  assign dn_only    = btn_down & ~btn_up;
  assign alarm_hit  = tick1s && (h == ah) && (m == am) && (s == 6'd0);
  assign snooze_hit = tick1s && (h == sh) && (m == sm) && (s == 6'd0);
  assign sm_tmp     = {1'b0, m} + SNOOZE_7;

  assign dbg_state = state;
  assign dbg_sh    = sh;
  assign dbg_sm    = sm;

  always_comb begin
    state_n = state;
    ah_n    = ah;
    am_n    = am;
    sh_n    = sh;
    sm_n    = sm;
    rc_n    = rc;
    led_n   = ring_led;
    case (state)
      S_OFF: begin
        if (!btn_off && btn_alarm) state_n = S_SET_H;
      end
      S_SET_H: begin
        if (btn_off)        state_n = S_OFF;
        else if (btn_alarm) state_n = S_SET_M;
        else if (up_only)   ah_n = (ah == 5'd23) ? 5'd0 : ah + 5'd1;
        else if (dn_only)   ah_n = (ah == 5'd0) ? 5'd23 : ah - 5'd1;
      end
      S_SET_M: begin
        if (btn_off)        state_n = S_OFF;
        else if (btn_alarm) state_n = S_ARMED;
        else if (up_only)   am_n = (am == 6'd59) ? 6'd0 : am + 6'd1;
        else if (dn_only)   am_n = (am == 6'd0) ? 6'd59 : am - 6'd1;
      end
      S_ARMED: begin
        if (btn_off)        state_n = S_OFF;
        else if (btn_alarm) state_n = S_SET_H;
        else if (alarm_hit) begin
          state_n = S_RINGING;
          rc_n    = 7'd0;
          led_n   = 1'b1;
        end
      end
      S_RINGING: begin
        if (btn_off) begin
          state_n = S_ARMED;
          rc_n    = 7'd0;
          led_n   = 1'b0;
        end else if (up_only) begin
          state_n = S_SNOOZE;
          rc_n    = 7'd0;
          led_n   = 1'b0;
          // Snooze target may roll into the next hour (and 23 into 0).
          if (sm_tmp >= 7'd60) begin
            sm_n = 6'(sm_tmp - 7'd60);
            sh_n = (h == 5'd23) ? 5'd0 : h + 5'd1;
          end else begin
            sm_n = sm_tmp[5:0];
            sh_n = h;
          end
        end else if (tick1s) begin
          if (rc == RC_LAST) begin
            state_n = S_ARMED;
            rc_n    = 7'd0;
            led_n   = 1'b0;
          end else begin
            rc_n  = rc + 7'd1;
            led_n = ~ring_led;
          end
        end
      end
      S_SNOOZE: begin
        if (btn_off) state_n = S_ARMED;
        else if (snooze_hit) begin
          state_n = S_RINGING;
          rc_n    = 7'd0;
          led_n   = 1'b1;
        end
      end
      default: begin
        state_n = S_OFF;
        rc_n    = 7'd0;
        led_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_OFF;
      ah        <= 5'(AH_INIT);
      am        <= 6'(AM_INIT);
      sh        <= 5'd0;
      sm        <= 6'd0;
      rc        <= 7'd0;
      ring_led  <= 1'b0;
      setting_h <= 1'b0;
      setting_m <= 1'b0;
      armed     <= 1'b0;
      ringing   <= 1'b0;
    end else begin
      state     <= state_n;
      ah        <= ah_n;
      am        <= am_n;
      sh        <= sh_n;
      sm        <= sm_n;
      rc        <= rc_n;
      ring_led  <= led_n;
      setting_h <= (state_n == S_SET_H);
      setting_m <= (state_n == S_SET_M);
      armed     <= (state_n == S_ARMED) || (state_n == S_RINGING) ||
                   (state_n == S_SNOOZE);
      ringing   <= (state_n == S_RINGING);
    end
  end

endmodule
